// File: rtl/branch_update_ctrl_pkg.sv
// Shared types for the branch update controller: FSM states and queue entry layout.
package branch_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        RECOVER = 2'd2
    } state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic            resolved;
        logic            taken;
    } entry_t;

endpackage

// File: rtl/branch_update_ctrl_if.sv
// Fetch / execute / predictor signal bundle of the branch update controller.
// Handshakes: lookup is served when lookup_req & lookup_gnt; an allocation
// transfers when alloc_valid & alloc_ready; resolve_valid is a one-cycle
// strobe with no back-pressure; mispredict is a one-cycle pulse.
interface branch_update_ctrl_if;
    import branch_pkg::*;

    logic            lookup_req;
    logic [PC_W-1:0] lookup_pc;
    logic            lookup_gnt;
    logic            lookup_pred;
    logic            alloc_valid;
    logic [PC_W-1:0] alloc_pc;
    logic            alloc_pred;
    logic            alloc_ready;
    logic            resolve_valid;
    logic            resolve_taken;
    logic            mispredict;
    logic [PC_W-1:0] mispredict_pc;
    logic [PC_W-1:0] pred_pc;
    logic            pred_update;
    logic            pred_actual_taken;
    logic            pred_prediction;

    // Fetch, execute and predictor side.
    modport master (
        output lookup_req, lookup_pc, alloc_valid, alloc_pc, alloc_pred,
               resolve_valid, resolve_taken, pred_prediction,
        input  lookup_gnt, lookup_pred, alloc_ready, mispredict, mispredict_pc,
               pred_pc, pred_update, pred_actual_taken
    );

    // Controller side.
    modport slave (
        input  lookup_req, lookup_pc, alloc_valid, alloc_pc, alloc_pred,
               resolve_valid, resolve_taken, pred_prediction,
        output lookup_gnt, lookup_pred, alloc_ready, mispredict, mispredict_pc,
               pred_pc, pred_update, pred_actual_taken
    );

endinterface

// File: rtl/branch_update_ctrl_queue.sv
// Circular in-flight branch queue with head (pop), resolve and tail (alloc) pointers.
module branch_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [PC_W-1:0]       push_pc,
    input  logic                  push_pred,
    input  logic                  resolve,
    input  logic                  resolve_taken,
    input  logic                  truncate,
    input  logic                  pop,
    output logic [PC_W-1:0]       head_pc,
    output logic                  head_taken,
    output logic [PC_W-1:0]       rsv_pc,
    output logic                  rsv_pred,
    output logic                  full,
    output logic                  head_resolved,
    output logic                  unresolved,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] head_q, head_d, rsv_q, rsv_d, tail_q, tail_d;
    entry_t      entries_q [DEPTH];
    entry_t      entries_d [DEPTH];

    assign head_pc       = entries_q[head_q[AW-1:0]].pc;
    assign head_taken    = entries_q[head_q[AW-1:0]].taken;
    assign rsv_pc        = entries_q[rsv_q[AW-1:0]].pc;
    assign rsv_pred      = entries_q[rsv_q[AW-1:0]].pred;
    assign full          = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign head_resolved = (head_q != tail_q) && entries_q[head_q[AW-1:0]].resolved;
    assign unresolved    = (rsv_q != tail_q);
    assign count         = tail_q - head_q;

    // Next pointers and entry contents; truncation after a mispredict beats any push.
    always_comb begin
        head_d    = head_q;
        rsv_d     = rsv_q;
        tail_d    = tail_q;
        entries_d = entries_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (resolve) begin
            entries_d[rsv_q[AW-1:0]].resolved = 1'b1;
            entries_d[rsv_q[AW-1:0]].taken    = resolve_taken;
            rsv_d                             = rsv_q + 1'b1;
        end
        if (truncate) begin
            tail_d = rsv_q + 1'b1;
        end else if (push) begin
            entries_d[tail_q[AW-1:0]] = '{pc: push_pc, pred: push_pred, resolved: 1'b0, taken: 1'b0};
            tail_d                    = tail_q + 1'b1;
        end
    end

    // Pointer and entry registers; reset empties the queue and clears resolved flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            rsv_q  <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].resolved <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            rsv_q     <= rsv_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Arbitrates the single-port branch predictor between fetch lookups and
// in-order training updates of resolved branches, and flags mispredicts.
module branch_update_ctrl
    import branch_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int GHR_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    branch_update_ctrl_if.slave    bus,
    output state_e                 dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);
    // GHR_BITS sizes only the external predictor; this marker block appears
    // in the hierarchy when the parameter set is unusable.
    if (GHR_BITS < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    end

    state_e          state_q, state_d;
    logic            mispredict_q, mispredict_d;
    logic [PC_W-1:0] mispredict_pc_q, mispredict_pc_d;

    logic            q_full, q_head_resolved, q_unresolved;
    logic [PC_W-1:0] q_head_pc, q_rsv_pc;
    logic            q_head_taken, q_rsv_pred;
    logic            update_grant, resolve_fire, mp_now, alloc_ready, alloc_fire;

    // Port arbitration and handshake qualification; everything is held off while in reset.
    always_comb begin
        update_grant = 1'b0;
        resolve_fire = 1'b0;
        mp_now       = 1'b0;
        alloc_ready  = 1'b0;
        if (!reset_n) begin
            update_grant = q_head_resolved && (state_q == DRAIN || !bus.lookup_req);
            resolve_fire = bus.resolve_valid && q_unresolved;
            mp_now       = resolve_fire && (bus.resolve_taken != q_rsv_pred);
            alloc_ready  = !q_full && (state_q != RECOVER) && !mp_now;
        end
        alloc_fire = bus.alloc_valid && alloc_ready;
    end

    branch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk),
        .rst           (reset_n),
        .push          (alloc_fire),
        .push_pc       (bus.alloc_pc),
        .push_pred     (bus.alloc_pred),
        .resolve       (resolve_fire),
        .resolve_taken (bus.resolve_taken),
        .truncate      (mp_now),
        .pop           (update_grant),
        .head_pc       (q_head_pc),
        .head_taken    (q_head_taken),
        .rsv_pc        (q_rsv_pc),
        .rsv_pred      (q_rsv_pred),
        .full          (q_full),
        .head_resolved (q_head_resolved),
        .unresolved    (q_unresolved),
        .count         (dbg_count)
    );

    // FSM next state; DRAIN lasts until its forced update has popped the head.
    always_comb begin
        state_d         = state_q;
        mispredict_d    = mp_now;
        mispredict_pc_d = mispredict_pc_q;
        case (state_q)
            RUN:     if (q_full && q_head_resolved) state_d = DRAIN;
            DRAIN:   if (!q_full || !q_head_resolved || update_grant) state_d = RUN;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
        if (mp_now) begin
            state_d         = RECOVER;
            mispredict_pc_d = q_rsv_pc;
        end
    end

    // FSM state and registered mispredict outputs.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q         <= RUN;
            mispredict_q    <= 1'b0;
            mispredict_pc_q <= '0;
        end else begin
            state_q         <= state_d;
            mispredict_q    <= mispredict_d;
            mispredict_pc_q <= mispredict_pc_d;
        end
    end

    assign bus.lookup_gnt        = bus.lookup_req && !update_grant && !reset_n;
    assign bus.lookup_pred       = bus.pred_prediction;
    assign bus.alloc_ready       = alloc_ready;
    assign bus.pred_update       = update_grant;
    assign bus.pred_pc           = update_grant ? q_head_pc : bus.lookup_pc;
    assign bus.pred_actual_taken = update_grant && q_head_taken;
    assign bus.mispredict        = mispredict_q;
    assign bus.mispredict_pc     = mispredict_pc_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Self-checking bench for branch_update_ctrl (DEPTH=4).
module tb_branch_update_ctrl;
    import branch_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    state_e     dbg_state;
    logic [2:0] dbg_count;

    int total = 0;
    int bad   = 0;

    // Expected predictor updates in order: {actual_taken, pc}.
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    branch_update_ctrl_if bus();

    // Toy predictor: prediction is a hash of the PC presented on the port.
    assign bus.pred_prediction = bus.pred_pc[2] ^ bus.pred_pc[5];

    branch_update_ctrl #(.DEPTH(DEPTH), .GHR_BITS(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every predictor update must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.pred_update === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL update_unexpected: pc=%h taken=%b, required no update", bus.pred_pc, bus.pred_actual_taken);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.pred_actual_taken, bus.pred_pc} !== mon_exp) begin
                    bad++;
                    $display("FAIL update_order: got taken=%b pc=%h, required taken=%b pc=%h",
                             bus.pred_actual_taken, bus.pred_pc, mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.lookup_req    = 1'b0;
        bus.lookup_pc     = '0;
        bus.alloc_valid   = 1'b0;
        bus.alloc_pc      = '0;
        bus.alloc_pred    = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_wait(input string name);
        int n;
        idle_inputs();
        n = 0;
        @(negedge clk);
        while (dbg_count != 3'd0 && n < 40) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        total++;
        if (dbg_count !== 3'd0) begin bad++; $display("FAIL %s_drain: count=%0d, required 0", name, dbg_count); end
        next_cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        idle_inputs();
        bus.lookup_req    = 1'b1;
        bus.alloc_valid   = 1'b1;
        bus.resolve_valid = 1'b1;
        @(negedge clk);
        total++; if (bus.lookup_gnt !== 1'b0) begin bad++; $display("FAIL reset_lookup_gnt: got %b, required 0", bus.lookup_gnt); end
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL reset_alloc_ready: got %b, required 0", bus.alloc_ready); end
        total++; if (bus.pred_update !== 1'b0) begin bad++; $display("FAIL reset_pred_update: got %b, required 0", bus.pred_update); end
        total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict: got %b, required 0", bus.mispredict); end
        total++; if (bus.mispredict_pc !== 32'h0) begin bad++; $display("FAIL reset_mispredict_pc: got %h, required 0", bus.mispredict_pc); end
        total++; if (dbg_state !== RUN) begin bad++; $display("FAIL reset_state: got %0d, required RUN", dbg_state); end
        total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", dbg_count); end
        next_cycle();
        reset_n = 1'b0;
        idle_inputs();
    endtask

    task automatic test_lookup();
        logic [31:0] pc;
        for (int i = 0; i < 4; i++) begin
            pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            bus.lookup_req = 1'b1;
            bus.lookup_pc  = pc;
            @(negedge clk);
            total++; if (bus.lookup_gnt !== 1'b1) begin bad++; $display("FAIL lookup_gnt: got %b, required 1", bus.lookup_gnt); end
            total++; if (bus.pred_pc !== pc) begin bad++; $display("FAIL lookup_pred_pc: got %h, required %h", bus.pred_pc, pc); end
            total++; if (bus.lookup_pred !== (pc[2] ^ pc[5])) begin bad++; $display("FAIL lookup_pred: got %b, required %b", bus.lookup_pred, pc[2] ^ pc[5]); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 2; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'h100 + 32'(4 * i);
            bus.alloc_pred  = 1'b0;
            @(negedge clk);
            total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL inorder_alloc_ready: got %b, required 1", bus.alloc_ready); end
            next_cycle();
        end
        bus.alloc_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.resolve_valid = 1'b1;
            bus.resolve_taken = 1'b0;
            exp_q.push_back({1'b0, 32'h100 + 32'(4 * i)});
            next_cycle();
            @(negedge clk);
            total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL inorder_mispredict: got %b, required 0", bus.mispredict); end
        end
        drain_wait("inorder");
    endtask

    task automatic test_full_drain();
        bus.lookup_req = 1'b1;
        bus.lookup_pc  = 32'h1000;
        for (int i = 0; i < DEPTH; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'h300 + 32'(4 * i);
            bus.alloc_pred  = 1'b1;
            @(negedge clk);
            total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL full_alloc_ready_fill: got %b, required 1", bus.alloc_ready); end
            next_cycle();
        end
        bus.alloc_pc      = 32'h3f0;
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        exp_q.push_back({1'b1, 32'h300});
        @(negedge clk);
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL full_alloc_ready: got %b, required 0", bus.alloc_ready); end
        total++; if (dbg_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d, required 4", dbg_count); end
        next_cycle();
        bus.alloc_valid   = 1'b0;
        bus.resolve_valid = 1'b0;
        @(negedge clk);
        total++; if (dbg_state !== RUN) begin bad++; $display("FAIL full_state_run: got %0d, required RUN", dbg_state); end
        total++; if (bus.lookup_gnt !== 1'b1) begin bad++; $display("FAIL full_lookup_wins: got %b, required 1", bus.lookup_gnt); end
        next_cycle();
        @(negedge clk);
        total++; if (dbg_state !== DRAIN) begin bad++; $display("FAIL drain_state: got %0d, required DRAIN", dbg_state); end
        total++; if (bus.lookup_gnt !== 1'b0) begin bad++; $display("FAIL drain_lookup_gnt: got %b, required 0", bus.lookup_gnt); end
        total++; if (bus.pred_update !== 1'b1) begin bad++; $display("FAIL drain_update: got %b, required 1", bus.pred_update); end
        next_cycle();
        @(negedge clk);
        total++; if (dbg_state !== RUN) begin bad++; $display("FAIL drain_exit_state: got %0d, required RUN", dbg_state); end
        total++; if (dbg_count !== 3'd3) begin bad++; $display("FAIL drain_exit_count: got %0d, required 3", dbg_count); end
        total++; if (bus.lookup_gnt !== 1'b1) begin bad++; $display("FAIL drain_exit_lookup_gnt: got %b, required 1", bus.lookup_gnt); end
        for (int i = 1; i < DEPTH; i++) begin
            bus.resolve_valid = 1'b1;
            bus.resolve_taken = 1'b1;
            exp_q.push_back({1'b1, 32'h300 + 32'(4 * i)});
            next_cycle();
        end
        drain_wait("full");
    endtask

    task automatic test_mispredict();
        bus.lookup_req = 1'b1;
        bus.lookup_pc  = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'h200 + 32'(4 * i);
            bus.alloc_pred  = (i == 1);
            next_cycle();
        end
        bus.alloc_pc      = 32'h20c;
        bus.alloc_pred    = 1'b0;
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        exp_q.push_back({1'b1, 32'h200});
        @(negedge clk);
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL mp_alloc_ready_same: got %b, required 0", bus.alloc_ready); end
        total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL mp_early: got %b, required 0", bus.mispredict); end
        next_cycle();
        bus.alloc_valid   = 1'b0;
        bus.resolve_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.mispredict !== 1'b1) begin bad++; $display("FAIL mp_pulse: got %b, required 1", bus.mispredict); end
        total++; if (bus.mispredict_pc !== 32'h200) begin bad++; $display("FAIL mp_pc: got %h, required 00000200", bus.mispredict_pc); end
        total++; if (dbg_count !== 3'd1) begin bad++; $display("FAIL mp_count: got %0d, required 1", dbg_count); end
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL mp_alloc_ready_recover: got %b, required 0", bus.alloc_ready); end
        total++; if (dbg_state !== RECOVER) begin bad++; $display("FAIL mp_state: got %0d, required RECOVER", dbg_state); end
        next_cycle();
        @(negedge clk);
        total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL mp_pulse_end: got %b, required 0", bus.mispredict); end
        total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL mp_alloc_ready_back: got %b, required 1", bus.alloc_ready); end
        total++; if (dbg_state !== RUN) begin bad++; $display("FAIL mp_state_back: got %0d, required RUN", dbg_state); end
        next_cycle();
        drain_wait("mispredict");
    endtask

    task automatic test_empty_resolve();
        for (int i = 0; i < 4; i++) begin
            bus.resolve_valid = (i < 3);
            bus.resolve_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL empty_mispredict: got %b, required 0", bus.mispredict); end
            total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL empty_count: got %0d, required 0", dbg_count); end
            total++; if (dbg_state !== RUN) begin bad++; $display("FAIL empty_state: got %0d, required RUN", dbg_state); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [32:0] pend[$];
        logic [32:0] ent;
        logic        p;
        for (int i = 0; i < 2; i++) begin
            p = 1'($urandom_range(0, 1));
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'h400 + 32'(4 * i);
            bus.alloc_pred  = p;
            pend.push_back({p, 32'h400 + 32'(4 * i)});
            next_cycle();
        end
        bus.alloc_valid = 1'b0;
        ent = pend.pop_front();
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = ent[32];
        exp_q.push_back(ent);
        @(negedge clk);
        total++; if (dbg_count !== 3'd2) begin bad++; $display("FAIL b2b_prefill_count: got %0d, required 2", dbg_count); end
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            p   = 1'($urandom_range(0, 1));
            ent = pend.pop_front();
            bus.resolve_valid = 1'b1;
            bus.resolve_taken = ent[32];
            exp_q.push_back(ent);
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'h408 + 32'(4 * i);
            bus.alloc_pred  = p;
            pend.push_back({p, 32'h408 + 32'(4 * i)});
            @(negedge clk);
            total++; if (bus.pred_update !== 1'b1) begin bad++; $display("FAIL b2b_update: got %b, required 1", bus.pred_update); end
            total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL b2b_alloc_ready: got %b, required 1", bus.alloc_ready); end
            total++; if (dbg_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d, required 2", dbg_count); end
            total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL b2b_mispredict: got %b, required 0", bus.mispredict); end
            next_cycle();
        end
        bus.alloc_valid = 1'b0;
        ent = pend.pop_front();
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = ent[32];
        exp_q.push_back(ent);
        next_cycle();
        drain_wait("b2b");
    endtask

    task automatic test_reset_midop();
        bus.lookup_req = 1'b1;
        bus.lookup_pc  = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'h500 + 32'(4 * i);
            bus.alloc_pred  = 1'b0;
            next_cycle();
        end
        bus.alloc_valid   = 1'b0;
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        next_cycle();
        // Head is resolved and lookup is dropped: only the reset holds the update off.
        reset_n = 1'b1;
        exp_q.delete();
        idle_inputs();
        bus.alloc_valid = 1'b1;
        bus.alloc_pc    = 32'h5f0;
        @(negedge clk);
        total++; if (bus.pred_update !== 1'b0) begin bad++; $display("FAIL midreset_update: got %b, required 0", bus.pred_update); end
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL midreset_alloc_ready: got %b, required 0", bus.alloc_ready); end
        next_cycle();
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL midreset_count: got %0d, required 0", dbg_count); end
        total++; if (dbg_state !== RUN) begin bad++; $display("FAIL midreset_state: got %0d, required RUN", dbg_state); end
        total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL midreset_mispredict: got %b, required 0", bus.mispredict); end
        for (int i = 0; i < 4; i++) next_cycle();
        @(negedge clk);
        total++; if (dbg_count !== 3'd0) begin bad++; $display("FAIL midreset_after_count: got %0d, required 0", dbg_count); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_in_order();
        test_full_drain();
        test_mispredict();
        test_empty_resolve();
        test_back_to_back();
        test_reset_midop();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL pending_updates: %0d outstanding, required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
